// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants for the execute-stage HI/LO unit.
//   HILO_W     data width of HI, LO and the operands
//   OP_*       operation codes presented on Op
//   state_t    control state of the HI/LO unit
package hilo_pkg;

    localparam int HILO_W = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
// div_iter_core: unsigned radix-2 restoring divider datapath.
//   Clk, Rst        clock, synchronous active-high reset
//   Load            capture Dividend/Divisor and perform the first step
//   Step            perform one more quotient-bit step on the held state
//   Dividend        unsigned dividend (magnitude)
//   Divisor         unsigned divisor (magnitude)
//   NextQuotient    quotient after one more step on the held state
//   NextRemainder   remainder after one more step on the held state
// Load counts as step 1, so after Load plus 30 Steps the Next* outputs
// carry the complete 32-step result; the parent commits them on that edge.
module div_iter_core
    import hilo_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic              Step,
    input  logic [HILO_W-1:0] Dividend,
    input  logic [HILO_W-1:0] Divisor,
    output logic [HILO_W-1:0] NextQuotient,
    output logic [HILO_W-1:0] NextRemainder
);

    logic [HILO_W-1:0] remReg;
    logic [HILO_W-1:0] quoReg;
    logic [HILO_W-1:0] divReg;
    logic [2*HILO_W-1:0] loadStep;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. Returns {rem, quo}.
    function automatic logic [2*HILO_W-1:0] divStep(
        input logic [HILO_W-1:0] rem,
        input logic [HILO_W-1:0] quo,
        input logic [HILO_W-1:0] dvs
    );
        logic [HILO_W:0]   shifted;
        logic [HILO_W+1:0] diff;
        shifted = {rem, quo[HILO_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs};
        // When the subtraction fails, shifted < divisor so it fits in HILO_W bits.
        if (!diff[HILO_W+1])
            return {diff[HILO_W-1:0], quo[HILO_W-2:0], 1'b1};
        else
            return {shifted[HILO_W-1:0], quo[HILO_W-2:0], 1'b0};
    endfunction

    assign loadStep = divStep('0, Dividend, Divisor);
    assign {NextRemainder, NextQuotient} = divStep(remReg, quoReg, divReg);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            remReg <= '0;
            quoReg <= '0;
            divReg <= '0;
        end else if (Load) begin
            {remReg, quoReg} <= loadStep;
            divReg           <= Divisor;
        end else if (Step) begin
            remReg <= NextRemainder;
            quoReg <= NextQuotient;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: execute-stage HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//   Clk, Rst   clock, synchronous active-high reset
//   Start, Op  HI/LO operation present in execute (Op from hilo_pkg)
//   A, B       forwarded rs / rt operands
//   HIOut      architectural HI register
//   LOOut      architectural LO register
//   Busy       multi-cycle operation in progress (registered)
//   Stall      hold upstream pipeline registers (combinational)
//   Done       one-cycle pulse the cycle after a mul/div commit
// Build option: define HILO_ACC_EN to add MADD/MSUB (signed accumulate into
// {HI,LO}); without it those codes behave as NOP.
// An op spends N cycles in execute (accept cycle + N-1 busy cycles). The
// counter is loaded with N-2 so the commit edge is the one where it reads 0.
// The divider always takes 32 steps, so DIV_CYCLES is expected to stay 32.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [3:0]        Op,
    input  logic [HILO_W-1:0] A,
    input  logic [HILO_W-1:0] B,
    output logic [HILO_W-1:0] HIOut,
    output logic [HILO_W-1:0] LOOut,
    output logic              Busy,
    output logic              Stall,
    output logic              Done
);

    localparam int CNT_W = 6;
    localparam bit MUL_MULTI = (MULT_CYCLES > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_MULTI ? MULT_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [HILO_W:0]    mulA, mulB;
    logic               divNegQ, divNegR, divZero;
    logic [HILO_W-1:0]  divARaw;
`ifdef HILO_ACC_EN
    logic               accAdd, accSub;
    logic               curAdd, curSub;
`endif

    logic               isMul, isDiv, divSigned, accept;
    logic [HILO_W:0]    extA, extB, opA, opB;
    logic [2*HILO_W-1:0] product, mulResult;
    logic [HILO_W-1:0]  absA, absB, nextQ, nextR, divHi, divLo;

    assign Busy = (state != ST_IDLE);

    always_comb begin
        isMul = (Op == OP_MULT) || (Op == OP_MULTU);
`ifdef HILO_ACC_EN
        isMul = isMul || (Op == OP_MADD) || (Op == OP_MSUB);
`endif
        isDiv     = (Op == OP_DIV) || (Op == OP_DIVU);
        divSigned = (Op == OP_DIV);
    end

    assign accept = (state == ST_IDLE) && Start;
    assign Stall  = (accept && ((isMul && MUL_MULTI) || isDiv)) || (Busy && counter != '0);

    // Multiplier: 33-bit operands carry the signedness, so a single signed
    // multiply serves MULT and MULTU. Uses the live inputs while idle so a
    // single-cycle configuration can commit on the accept edge.
    assign extA = {(Op != OP_MULTU) & A[HILO_W-1], A};
    assign extB = {(Op != OP_MULTU) & B[HILO_W-1], B};
    assign opA  = Busy ? mulA : extA;
    assign opB  = Busy ? mulB : extB;

    always_comb begin
        logic [2*HILO_W-1:0] wideA, wideB;
        wideA   = {{(HILO_W-1){opA[HILO_W]}}, opA};
        wideB   = {{(HILO_W-1){opB[HILO_W]}}, opB};
        product = wideA * wideB;
    end

`ifdef HILO_ACC_EN
    assign curAdd = Busy ? accAdd : (Op == OP_MADD);
    assign curSub = Busy ? accSub : (Op == OP_MSUB);
    always_comb begin
        mulResult = product;
        if (curAdd)      mulResult = {HIOut, LOOut} + product;
        else if (curSub) mulResult = {HIOut, LOOut} - product;
    end
`else
    assign mulResult = product;
`endif

    // Divider runs on magnitudes; signs are reapplied at commit.
    assign absA = (divSigned && A[HILO_W-1]) ? -A : A;
    assign absB = (divSigned && B[HILO_W-1]) ? -B : B;

    div_iter_core uDivCore (
        .Clk           (Clk),
        .Rst           (Rst),
        .Load          (accept && isDiv),
        .Step          (state == ST_DIV),
        .Dividend      (absA),
        .Divisor       (absB),
        .NextQuotient  (nextQ),
        .NextRemainder (nextR)
    );

    // 0x80000000 / -1 needs no special case: magnitude quotient 0x80000000
    // with equal signs is already the required result.
    assign divLo = divZero ? '1 : (divNegQ ? -nextQ : nextQ);
    assign divHi = divZero ? divARaw : (divNegR ? -nextR : nextR);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            counter <= '0;
            HIOut   <= '0;
            LOOut   <= '0;
            Done    <= 1'b0;
            mulA    <= '0;
            mulB    <= '0;
            divNegQ <= 1'b0;
            divNegR <= 1'b0;
            divZero <= 1'b0;
            divARaw <= '0;
`ifdef HILO_ACC_EN
            accAdd  <= 1'b0;
            accSub  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: if (Start) begin
                    if (Op == OP_MTHI) begin
                        HIOut <= A;
                    end else if (Op == OP_MTLO) begin
                        LOOut <= A;
                    end else if (isMul) begin
                        mulA <= extA;
                        mulB <= extB;
`ifdef HILO_ACC_EN
                        accAdd <= (Op == OP_MADD);
                        accSub <= (Op == OP_MSUB);
`endif
                        if (MUL_MULTI) begin
                            counter <= MUL_LOAD;
                            state   <= ST_MUL;
                        end else begin
                            {HIOut, LOOut} <= mulResult;
                            Done           <= 1'b1;
                        end
                    end else if (isDiv) begin
                        divNegQ <= divSigned && (A[HILO_W-1] ^ B[HILO_W-1]);
                        divNegR <= divSigned && A[HILO_W-1];
                        divZero <= (B == '0);
                        divARaw <= A;
                        counter <= DIV_LOAD;
                        state   <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (counter == '0) begin
                        {HIOut, LOOut} <= mulResult;
                        Done           <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (counter == '0) begin
                        HIOut <= divHi;
                        LOOut <= divLo;
                        Done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected {HI,LO}
// for each mul/div; a monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst, Start;
    logic [3:0]  Op;
    logic [31:0] A, B, HIOut, LOOut;
    logic        Busy, Stall, Done;

    int errors = 0;
    int checks = 0;
    int doneSeen = 0;
    logic [63:0] expQ[$];

    always #5 Clk = ~Clk;

    hilo_muldiv_unit dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .HIOut(HIOut), .LOOut(LOOut), .Busy(Busy), .Stall(Stall), .Done(Done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    initial forever begin
        @(negedge Clk);
        if (Rst === 1'b0 && Done === 1'b1) begin
            doneSeen++;
            if (expQ.size() == 0) begin
                chk("spurious Done", {31'b0, Done}, 32'h0);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                chk("HI at Done", HIOut, e[63:32]);
                chk("LO at Done", LOOut, e[31:0]);
            end
        end
    end

    // Issue one op, holding Start high while Stall is asserted (as the
    // decode/execute register would), then count stalls and Done pulses.
    task automatic runOp(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int expStalls, input bit expDone,
                         input logic [31:0] eHi, input logic [31:0] eLo);
        int stalls;
        int d0;
        if (expDone) expQ.push_back({eHi, eLo});
        d0 = doneSeen;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        #1;
        stalls = 0;
        while (Stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge Clk);
            #1;
        end
        chk({name, " stalls"}, stalls, expStalls);
        @(posedge Clk);
        #1;
        Start = 1'b0; Op = OP_NOP;
        repeat (3) @(negedge Clk);
        #1;
        chk({name, " done pulses"}, doneSeen - d0, {31'b0, expDone});
        if (!expDone) begin
            chk({name, " HI"}, HIOut, eHi);
            chk({name, " LO"}, LOOut, eLo);
        end
    endtask

    initial begin
        int d0;
        Rst = 1'b1; Start = 1'b0; Op = OP_NOP; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("reset HI", HIOut, 32'h0);
        chk("reset LO", LOOut, 32'h0);
        chk("reset Busy", {31'b0, Busy}, 32'h0);
        chk("reset Done", {31'b0, Done}, 32'h0);
        chk("reset Stall", {31'b0, Stall}, 32'h0);

        runOp("MTHI", OP_MTHI, 32'h12345678, 32'h0, 0, 1'b0, 32'h12345678, 32'h0);
        runOp("MTLO", OP_MTLO, 32'h9ABCDEF0, 32'h0, 0, 1'b0, 32'h12345678, 32'h9ABCDEF0);
        runOp("MULT -2*3", OP_MULT, 32'hFFFFFFFE, 32'd3, 3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        runOp("MULTU", OP_MULTU, 32'hFFFFFFFE, 32'd3, 3, 1'b1, 32'h00000002, 32'hFFFFFFFA);

        // Reset 10 cycles into a DIV: abort, no commit, HI/LO cleared.
        d0 = doneSeen;
        @(negedge Clk);
        Start = 1'b1; Op = OP_DIV; A = 32'hFFFFFFF9; B = 32'd2;
        repeat (10) @(negedge Clk);
        Rst = 1'b1; Start = 1'b0; Op = OP_NOP;
        @(posedge Clk);
        #1;
        chk("abort Busy", {31'b0, Busy}, 32'h0);
        chk("abort Stall", {31'b0, Stall}, 32'h0);
        chk("abort HI", HIOut, 32'h0);
        chk("abort LO", LOOut, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (40) @(negedge Clk);
        chk("abort done pulses", doneSeen - d0, 32'h0);

        runOp("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 31, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 31, 1'b1, 32'h00000001, 32'hFFFFFFFD);
        runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 31, 1'b1, 32'd2, 32'd14);
        runOp("DIVU /0", OP_DIVU, 32'h55, 32'h0, 31, 1'b1, 32'h55, 32'hFFFFFFFF);
        runOp("DIV -5/0", OP_DIV, 32'hFFFFFFFB, 32'h0, 31, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF);
        runOp("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 31, 1'b1, 32'h0, 32'h80000000);
        runOp("MULT max", OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 3, 1'b1, 32'h3FFFFFFF, 32'h00000001);
        runOp("MULT min", OP_MULT, 32'h80000000, 32'h80000000, 3, 1'b1, 32'h40000000, 32'h0);

        runOp("MTHI 0", OP_MTHI, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h0);
        runOp("MTLO 10", OP_MTLO, 32'd10, 32'h0, 0, 1'b0, 32'h0, 32'd10);
`ifdef HILO_ACC_EN
        runOp("MADD", OP_MADD, 32'd3, 32'd4, 3, 1'b1, 32'h0, 32'd22);
        runOp("MSUB", OP_MSUB, 32'd5, 32'd5, 3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
        runOp("op7 ignored", OP_MADD, 32'd3, 32'd4, 0, 1'b0, 32'h0, 32'd10);
        runOp("op8 ignored", OP_MSUB, 32'd5, 32'd5, 0, 1'b0, 32'h0, 32'd10);
`endif
        runOp("op15 ignored", 4'hF, 32'd5, 32'd5, 0, 1'b0, HIOut, LOOut);
        runOp("NOP ignored", OP_NOP, 32'd9, 32'd9, 0, 1'b0, HIOut, LOOut);

        chk("scoreboard drained", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
